// File: rtl/multi_pkg.sv
// Shared constants for the multi-cycle MIPS control FSM: opcodes, state codes
// and datapath mux encodings.
package multi_pkg;

  localparam int unsigned CNT_W = 3;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [3:0] {
    StIf   = 4'd0,
    StId   = 4'd1,
    StMa   = 4'd2,
    StMrd  = 4'd3,
    StLwb  = 4'd4,
    StMwr  = 4'd5,
    StEx   = 4'd6,
    StRwb  = 4'd7,
    StBr   = 4'd8,
    StJp   = 4'd9,
    StTrap = 4'd10
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // Instruction class one-hot: [4]J [3]BEQ [2]LW [1]SW [0]R; zero if unknown.
  function automatic logic [4:0] op_class(input logic [5:0] op);
    logic [4:0] cls;
    cls = 5'b00000;
    case (op)
      OP_R:    cls = 5'b00001;
      OP_SW:   cls = 5'b00010;
      OP_LW:   cls = 5'b00100;
      OP_BEQ:  cls = 5'b01000;
      OP_J:    cls = 5'b10000;
      default: cls = 5'b00000;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_wait_cnt.sv
// Memory wait-state counter: cleared on entry to a memory state, counts while
// in it, and flags the final cycle of a MEM_LAT-cycle access.
module multi_wait_cnt
  import multi_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
    $error("multi_wait_cnt: MEM_LAT must be in 1..7");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(MEM_LAT - 1));

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with MEM_LAT-cycle memory
// accesses. Define MULTI_CTRL_ILLEGAL_TRAP_EN to lock unknown opcodes in TRAP;
// otherwise they are treated as NOPs.
module multi_cycle_ctrl
  import multi_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned SW_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      OP,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUop,
  output logic [1:0]      PCSource,
  output logic [SW_W-1:0] state,
  output logic [4:0]      LED
);

  state_e     state_q, state_d;
  logic [4:0] led_q, led_d;
  logic       cnt_clr, cnt_en, last;

  // Clearing on every state change is equivalent to clearing on entry, since
  // the count is only observed inside the memory states.
  assign cnt_clr = (state_d != state_q);
  assign cnt_en  = (state_q == StIf) || (state_q == StMrd) || (state_q == StMwr);

  multi_wait_cnt #(
    .MEM_LAT(MEM_LAT)
  ) u_wait_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .last_o(last)
  );

  // State and class registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIf;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
    end
  end

  // Next-state logic and Moore output decode of state plus the last flag.
  always_comb begin
    state_d     = state_q;
    led_d       = led_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUop       = ALU_ADD;
    PCSource    = PCS_ALU;

    unique case (state_q)
      StIf: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        if (last) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = StId;
        end
      end
      StId: begin
        ALUSrcB = SRCB_IMM_SH;
        led_d   = op_class(OP);
        case (OP)
          OP_LW, OP_SW: state_d = StMa;
          OP_R:         state_d = StEx;
          OP_BEQ:       state_d = StBr;
          OP_J:         state_d = StJp;
          default: begin
`ifdef MULTI_CTRL_ILLEGAL_TRAP_EN
            state_d = StTrap;
            led_d   = 5'b11111;
`else
            state_d = StIf;
`endif
          end
        endcase
      end
      StMa: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = led_q[2] ? StMrd : StMwr;
      end
      StMrd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (last) state_d = StLwb;
      end
      StLwb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = StIf;
      end
      StMwr: begin
        IorD = 1'b1;
        if (last) begin
          MemWrite = 1'b1;
          state_d  = StIf;
        end
      end
      StEx: begin
        ALUSrcA = 1'b1;
        ALUop   = ALU_FUNCT;
        state_d = StRwb;
      end
      StRwb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = StIf;
      end
      StBr: begin
        ALUSrcA     = 1'b1;
        ALUop       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCS_ALUOUT;
        state_d     = StIf;
      end
      StJp: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
        state_d  = StIf;
      end
`ifdef MULTI_CTRL_ILLEGAL_TRAP_EN
      StTrap: state_d = StTrap;
`endif
      default: state_d = StIf;
    endcase

    // Reset masks every output so an aborted instruction cannot write.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_B;
      ALUop       = ALU_ADD;
      PCSource    = PCS_ALU;
    end
  end

  assign state = rst ? '0 : SW_W'(state_q);
  assign LED   = rst ? '0 : led_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: one instance with MEM_LAT=1 and one with
// MEM_LAT=3 share clock, reset and opcode; each check selects one of them.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op  = 6'd0;
  logic       sel = 1'b0;

  always #5 clk = ~clk;

  logic       pw1, pwc1, iod1, mr1, mw1, irw1, m2r1, rd1, rw1, asa1;
  logic [1:0] asb1, aop1, pcs1;
  logic [3:0] st1;
  logic [4:0] led1;
  logic       pw3, pwc3, iod3, mr3, mw3, irw3, m2r3, rd3, rw3, asa3;
  logic [1:0] asb3, aop3, pcs3;
  logic [3:0] st3;
  logic [4:0] led3;

  multi_cycle_ctrl #(.MEM_LAT(1), .SW_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .OP(op),
    .PCWrite(pw1), .PCWriteCond(pwc1), .IorD(iod1), .MemRead(mr1), .MemWrite(mw1),
    .IRWrite(irw1), .MemtoReg(m2r1), .RegDst(rd1), .RegWrite(rw1), .ALUSrcA(asa1),
    .ALUSrcB(asb1), .ALUop(aop1), .PCSource(pcs1), .state(st1), .LED(led1)
  );

  multi_cycle_ctrl #(.MEM_LAT(3), .SW_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .OP(op),
    .PCWrite(pw3), .PCWriteCond(pwc3), .IorD(iod3), .MemRead(mr3), .MemWrite(mw3),
    .IRWrite(irw3), .MemtoReg(m2r3), .RegDst(rd3), .RegWrite(rw3), .ALUSrcA(asa3),
    .ALUSrcB(asb3), .ALUop(aop3), .PCSource(pcs3), .state(st3), .LED(led3)
  );

  // ctl = {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //        RegWrite,ALUSrcA,ALUSrcB[1:0],ALUop[1:0],PCSource[1:0]}
  logic [15:0] ctl1, ctl3, ctl;
  logic [3:0]  st;
  logic [4:0]  led;
  assign ctl1 = {pw1, pwc1, iod1, mr1, mw1, irw1, m2r1, rd1, rw1, asa1, asb1, aop1, pcs1};
  assign ctl3 = {pw3, pwc3, iod3, mr3, mw3, irw3, m2r3, rd3, rw3, asa3, asb3, aop3, pcs3};
  assign ctl  = sel ? ctl3 : ctl1;
  assign st   = sel ? st3 : st1;
  assign led  = sel ? led3 : led1;

  localparam logic [15:0] C_ZERO = 16'h0000;
  localparam logic [15:0] C_IF   = 16'h1010;
  localparam logic [15:0] C_IFL  = 16'h9410;
  localparam logic [15:0] C_ID   = 16'h0030;
  localparam logic [15:0] C_MA   = 16'h0060;
  localparam logic [15:0] C_MRD  = 16'h3000;
  localparam logic [15:0] C_LWB  = 16'h0280;
  localparam logic [15:0] C_MWR  = 16'h2000;
  localparam logic [15:0] C_MWRL = 16'h2800;
  localparam logic [15:0] C_EX   = 16'h0048;
  localparam logic [15:0] C_RWB  = 16'h0180;
  localparam logic [15:0] C_BR   = 16'h4045;
  localparam logic [15:0] C_JP   = 16'h8002;

  localparam logic [5:0] X = 6'h3f; // junk opcode outside ID

  typedef struct {
    logic        sel;
    logic        rst;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [4:0]  led;
  } vec_t;

  vec_t tv[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic s, input logic r, input logic [5:0] o,
                     input logic [3:0] es, input logic [15:0] ec, input logic [4:0] el);
    vec_t v;
    v.sel = s; v.rst = r; v.op = o; v.st = es; v.ctl = ec; v.led = el;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  // One cycle: drive just after the rising edge, sample on the falling edge.
  task automatic cyc(input logic r, input logic [5:0] o);
    @(posedge clk);
    #1;
    rst = r;
    op  = o;
    @(negedge clk);
  endtask

  // Runs one instruction from reset and counts its cycles and write pulses.
  task automatic run_instr(input string nm, input logic s, input logic [5:0] o,
                           input int exp_cyc, input int exp_mw, input int exp_rw);
    int  ncyc, nmw, nrw;
    bit  seen, done;
    ncyc = 0; nmw = 0; nrw = 0; seen = 0; done = 0;
    sel = s;
    cyc(1'b1, o);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, o);
      if (seen && st == 4'd0) begin
        done = 1;
        break;
      end
      if (st != 4'd0) seen = 1;
      ncyc++;
      nmw += int'(ctl[11]);
      nrw += int'(ctl[7]);
    end
    chk({nm, "_done"}, 0, 32'(done), 32'd1);
    chk({nm, "_cycles"}, 0, ncyc, exp_cyc);
    chk({nm, "_memwrite"}, 0, nmw, exp_mw);
    chk({nm, "_regwrite"}, 0, nrw, exp_rw);
  endtask

  initial begin
    // Reset held 3 cycles, then R / BEQ / J on MEM_LAT=1.
    add(0, 1, 0, 0, C_ZERO, 0);
    add(0, 1, 0, 0, C_ZERO, 0);
    add(0, 1, 0, 0, C_ZERO, 0);
    add(0, 0, X,      0, C_IFL, 5'b00000);
    add(0, 0, 6'd0,   1, C_ID,  5'b00000);
    add(0, 0, X,      6, C_EX,  5'b00001);
    add(0, 0, X,      7, C_RWB, 5'b00001);
    add(0, 0, X,      0, C_IFL, 5'b00001);
    add(0, 0, 6'h04,  1, C_ID,  5'b00001);
    add(0, 0, X,      8, C_BR,  5'b01000);
    add(0, 0, X,      0, C_IFL, 5'b01000);
    add(0, 0, 6'h02,  1, C_ID,  5'b01000);
    add(0, 0, X,      9, C_JP,  5'b10000);
    add(0, 0, X,      0, C_IFL, 5'b10000);
    // LW then SW on MEM_LAT=3.
    add(1, 1, X, 0, C_ZERO, 0);
    add(1, 0, X,      0, C_IF,   5'b00000);
    add(1, 0, X,      0, C_IF,   5'b00000);
    add(1, 0, X,      0, C_IFL,  5'b00000);
    add(1, 0, 6'h23,  1, C_ID,   5'b00000);
    add(1, 0, X,      2, C_MA,   5'b00100);
    add(1, 0, X,      3, C_MRD,  5'b00100);
    add(1, 0, X,      3, C_MRD,  5'b00100);
    add(1, 0, X,      3, C_MRD,  5'b00100);
    add(1, 0, X,      4, C_LWB,  5'b00100);
    add(1, 0, X,      0, C_IF,   5'b00100);
    add(1, 0, X,      0, C_IF,   5'b00100);
    add(1, 0, X,      0, C_IFL,  5'b00100);
    add(1, 0, 6'h2b,  1, C_ID,   5'b00100);
    add(1, 0, X,      2, C_MA,   5'b00010);
    add(1, 0, X,      5, C_MWR,  5'b00010);
    add(1, 0, X,      5, C_MWR,  5'b00010);
    add(1, 0, X,      5, C_MWRL, 5'b00010);
    add(1, 0, X,      0, C_IF,   5'b00010);
    // Illegal opcode.
    add(1, 0, X,      0, C_IF,   5'b00010);
    add(1, 0, X,      0, C_IFL,  5'b00010);
    add(1, 0, 6'h3f,  1, C_ID,   5'b00010);
`ifdef MULTI_CTRL_ILLEGAL_TRAP_EN
    add(1, 0, 6'h00, 10, C_ZERO, 5'b11111);
    add(1, 0, 6'h00, 10, C_ZERO, 5'b11111);
    add(1, 0, 6'h00, 10, C_ZERO, 5'b11111);
`else
    add(1, 0, X,      0, C_IF,   5'b00000);
    add(1, 0, X,      0, C_IF,   5'b00000);
    add(1, 0, X,      0, C_IFL,  5'b00000);
`endif
    // Reset in MRD aborts the LW: no LWB, LED cleared.
    add(1, 1, X, 0, C_ZERO, 0);
    add(1, 0, X,      0, C_IF,   5'b00000);
    add(1, 0, X,      0, C_IF,   5'b00000);
    add(1, 0, X,      0, C_IFL,  5'b00000);
    add(1, 0, 6'h23,  1, C_ID,   5'b00000);
    add(1, 0, X,      2, C_MA,   5'b00100);
    add(1, 0, X,      3, C_MRD,  5'b00100);
    add(1, 1, X,      0, C_ZERO, 5'b00000);
    add(1, 0, X,      0, C_IF,   5'b00000);
    add(1, 0, X,      0, C_IF,   5'b00000);
    add(1, 0, X,      0, C_IFL,  5'b00000);

    foreach (tv[i]) begin
      sel = tv[i].sel;
      cyc(tv[i].rst, tv[i].op);
      chk("state", i, 32'(st), 32'(tv[i].st));
      chk("ctl", i, 32'(ctl), 32'(tv[i].ctl));
      chk("led", i, 32'(led), 32'(tv[i].led));
    end

    // Whole-instruction cycle counts and write pulse counts.
    run_instr("r_l1",   1'b0, 6'h00, 4, 0, 1);
    run_instr("lw_l3",  1'b1, 6'h23, 9, 0, 1);
    run_instr("sw_l3",  1'b1, 6'h2b, 8, 1, 0);
    run_instr("beq_l3", 1'b1, 6'h04, 5, 0, 0);
    run_instr("j_l1",   1'b0, 6'h02, 3, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Control FSM for the multi-cycle variant of the MIPS datapath.
- Sequences one shared memory, the ALU, the PC and the IR through IF/ID/EX/MEM/WB steps.
- Supports R-type, LW, SW, BEQ and J; inserts configurable memory wait states.
- Sits between the IR opcode field and every datapath mux, write enable and ALU control.

Parameters:
MEM_LAT, 1, memory access latency in cycles (legal 1..7); IF, MEM-read and MEM-write states each last MEM_LAT cycles
SW_W, 4, width of state debug output

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
OP  in  6  opcode from IR[31:26], valid from ID onward
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load qualified by ALU zero (external AND/OR)
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read enable
MemWrite  out  1  memory write enable
IRWrite  out  1  IR load
MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR
RegDst  out  1  write register: 0=rt, 1=rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=const 4, 10=sext imm, 11=sext imm<<2
ALUop  out  2  00=add, 01=sub, 10=funct
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
state  out  SW_W  current state code, for the 7-seg mux
LED  out  5  latched class one-hot: [4]J [3]BEQ [2]LW [1]SW [0]R

Behaviour:
- While rst=1, all outputs are 0. At the edge, state<=IF, wait counter<=0, LED<=0.
- Reset mid-instruction aborts it; no partial write occurs after the reset edge.
- State codes: IF=0, ID=1, MA=2, MRD=3, LWB=4, MWR=5, EX=6, RWB=7, BR=8, JP=9, TRAP=10.
- Wait counter: cleared on entry to IF, MRD and MWR; increments each cycle while in one of them; "last" = (cnt==MEM_LAT-1).
- IF:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
  - IRWrite=1 and PCWrite=1 only in the last cycle, then go to ID.
- ID:
  - ALUSrcA=0, ALUSrcB=11, ALUop=00.
  - Latch LED from OP.
  - Next state: 100011/101011->MA; 000000->EX; 000100->BR; 000010->JP; otherwise see Optional Feature.
- MA: ALUSrcA=1, ALUSrcB=10, ALUop=00. Next is MRD for LW, MWR for SW.
- MRD: MemRead=1, IorD=1; leaves to LWB in the last cycle.
- LWB: RegWrite=1, RegDst=0, MemtoReg=1; then IF.
- MWR: IorD=1; MemWrite=1 only in the last cycle (exactly one write pulse); then IF.
- EX: ALUSrcA=1, ALUSrcB=00, ALUop=10; then RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0; then IF.
- BR: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01; then IF.
- JP: PCWrite=1, PCSource=10; then IF.
- Any output not listed for a state is 0. Outputs are a Moore decode of state plus the "last" flag.
- Instruction cycle counts (L=MEM_LAT):
  - R: L+3
  - LW: 2L+3
  - SW: 2L+2
  - BEQ: L+2
  - J: L+2
- OP is sampled only in ID. OP changes in other states are ignored.
- An out-of-range MEM_LAT (0 or >7) is a synthesis-time error.

Optional Feature:
- Macro: MULTI_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in ID goes to TRAP.
  - TRAP drives all control outputs to 0, state=10 and LED=5'b11111.
  - TRAP is left only by rst.
- Undefined:
  - An unknown opcode in ID returns to IF (treated as NOP, PC already advanced).
  - LED=0 for that instruction. The TRAP code is unused.

Decomposition:
- Package multi_pkg holds:
  - opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_J)
  - state codes
  - ALUop, ALUSrcB and PCSource encodings
- One sub-module, multi_wait_cnt: 3-bit counter with clear and a last flag, parameterised by MEM_LAT.

Test Plan:
- Reset: hold rst 3 cycles, MEM_LAT=1 -> all outputs 0 during reset; first cycle after reset state=0, MemRead=1, IRWrite=1, PCWrite=1.
- R-type, OP=000000, MEM_LAT=1 -> states 0,1,6,7,0 (4 cycles); RegWrite=1, RegDst=1 only in state 7; LED=00001.
- LW, OP=100011, MEM_LAT=3 -> 9 cycles; IRWrite high only in cycle 3; MemRead with IorD=1 for 3 cycles; RegWrite with MemtoReg=1 once; LED=00100.
- SW, OP=101011, MEM_LAT=3 -> exactly one MemWrite pulse, in the 3rd MWR cycle, with IorD=1; RegWrite never asserted; 8 cycles total.
- BEQ/J back-to-back, MEM_LAT=1:
  - BEQ: state 8 with PCWriteCond=1, PCSource=01, ALUop=01.
  - J: state 9 with PCWrite=1, PCSource=10.
  - Each takes 3 cycles.
- Illegal OP=111111 plus reset mid-LW:
  - Macro defined -> state sticks at 10, LED=11111, outputs 0.
  - Macro undefined -> back to IF after ID.
  - rst asserted in MRD -> next edge state=0, no RegWrite issued.
